fft_stage_sequencer: RTL and testbench

Controller that sequences the radix-2 butterfly datapath through all stages of an in-place, ping-pong-banked, decimation-in-time FFT. Per butterfly it issues two sample-RAM read addresses and one twiddle-ROM address, then the matching write-back addresses, with the write pipelined to account for RAM read latency. It sits between the top-level FFT control (start/done) and the sample RAM banks, twiddle ROM and butterfly unit. Input samples are pre-loaded into bank 0 in bit-reversed order.

---
 rtl/fft_stage_sequencer.sv | 158 +++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// Address/strobe sequencer for an in-place, ping-pong-banked radix-2 DIT FFT.
// Optional feature macro SEQ_STALL_EN adds an i_stall input that freezes the sequencer.
module fft_stage_sequencer #(
    parameter int unsigned LOG2N  = 4,
    parameter int unsigned ADDR_W = LOG2N
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_start,
`ifdef SEQ_STALL_EN
    input  logic              i_stall,
`endif
    output logic              o_busy,
    output logic              o_done,
    output logic [3:0]        o_stage,
    output logic              o_bank,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addrA,
    output logic [ADDR_W-1:0] o_rd_addrB,
    output logic [LOG2N-2:0]  o_tw_addr,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addrA,
    output logic [ADDR_W-1:0] o_wr_addrB
);

    localparam int unsigned   KW     = LOG2N - 1;
    localparam logic [KW-1:0] K_LAST = '1;
    localparam logic [3:0]    S_LAST = 4'(LOG2N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic [KW-1:0]     k;
    logic [KW-1:0]     k_inc;
    logic              drain_cnt;
    logic              rd_en_q;
    logic              wr_en_q;
    logic              pipe_en;
    logic [ADDR_W-1:0] pipe_a;
    logic [ADDR_W-1:0] pipe_b;
    logic              adv;

    // Lower butterfly address: group base (grp*2*half) plus position within the group.
    function automatic logic [ADDR_W-1:0] base_addr(input logic [3:0] st, input logic [KW-1:0] kk);
        logic [ADDR_W-1:0] kx;
        logic [ADDR_W-1:0] lo_mask;
        kx      = ADDR_W'(kk);
        lo_mask = (ADDR_W'(1) << st) - ADDR_W'(1);
        return ((kx >> st) << (st + 4'd1)) | (kx & lo_mask);
    endfunction

    function automatic logic [ADDR_W-1:0] half_of(input logic [3:0] st);
        return ADDR_W'(1) << st;
    endfunction

    function automatic logic [KW-1:0] tw_of(input logic [3:0] st, input logic [KW-1:0] kk);
        logic [KW-1:0] pos;
        pos = kk & ((KW'(1) << st) - KW'(1));
        return pos << (S_LAST - st);
    endfunction

    assign k_inc = k + KW'(1);

`ifdef SEQ_STALL_EN
    assign adv     = ~i_stall;
`else
    assign adv     = 1'b1;
`endif
    // Strobes are masked while frozen so a held address is never issued twice.
    assign o_rd_en = rd_en_q & adv;
    assign o_wr_en = wr_en_q & adv;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state      <= IDLE;
            k          <= '0;
            drain_cnt  <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_stage    <= '0;
            o_bank     <= 1'b0;
            rd_en_q    <= 1'b0;
            o_rd_addrA <= '0;
            o_rd_addrB <= '0;
            o_tw_addr  <= '0;
            pipe_en    <= 1'b0;
            pipe_a     <= '0;
            pipe_b     <= '0;
            wr_en_q    <= 1'b0;
            o_wr_addrA <= '0;
            o_wr_addrB <= '0;
        end else if (adv) begin
            // Two-cycle write delay: RAM/ROM read latency plus registered butterfly.
            pipe_en    <= rd_en_q;
            pipe_a     <= o_rd_addrA;
            pipe_b     <= o_rd_addrB;
            wr_en_q    <= pipe_en;
            o_wr_addrA <= pipe_a;
            o_wr_addrB <= pipe_b;
            o_done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state      <= RUN;
                        k          <= '0;
                        o_stage    <= '0;
                        o_bank     <= 1'b0;
                        o_busy     <= 1'b1;
                        rd_en_q    <= 1'b1;
                        o_rd_addrA <= '0;
                        o_rd_addrB <= ADDR_W'(1);
                        o_tw_addr  <= '0;
                    end
                end
                RUN: begin
                    if (k == K_LAST) begin
                        state     <= DRAIN;
                        rd_en_q   <= 1'b0;
                        drain_cnt <= 1'b0;
                    end else begin
                        k          <= k_inc;
                        o_rd_addrA <= base_addr(o_stage, k_inc);
                        o_rd_addrB <= base_addr(o_stage, k_inc) + half_of(o_stage);
                        o_tw_addr  <= tw_of(o_stage, k_inc);
                    end
                end
                DRAIN: begin
                    if (!drain_cnt) begin
                        drain_cnt <= 1'b1;
                    end else begin
                        // Bank flips on every stage exit, so after the last one it names the result bank.
                        o_bank <= ~o_bank;
                        if (o_stage < S_LAST) begin
                            state      <= RUN;
                            k          <= '0;
                            o_stage    <= o_stage + 4'd1;
                            rd_en_q    <= 1'b1;
                            o_rd_addrA <= '0;
                            o_rd_addrB <= half_of(o_stage + 4'd1);
                            o_tw_addr  <= '0;
                        end else begin
                            state  <= DONE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: directed LOG2N=3 vectors, randomized LOG2N=4 runs
// against a cycle model, and a behavioural FFT datapath compared with a direct DFT.
module tb_fft_stage_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start3, start4;
    logic busy3, done3, bank3, rd_en3, we3;
    logic [3:0] stage3;
    logic [2:0] ra3, rb3, wa3, wb3;
    logic [1:0] tw3;
    logic busy4, done4, bank4, rd_en4, we4;
    logic [3:0] stage4;
    logic [3:0] ra4, rb4, wa4, wb4;
    logic [2:0] tw4;
`ifdef SEQ_STALL_EN
    logic stall3, stall4;
`endif

    fft_stage_sequencer #(.LOG2N(3)) dut3 (
        .i_CLK(clk), .i_RST(rst), .i_start(start3),
`ifdef SEQ_STALL_EN
        .i_stall(stall3),
`endif
        .o_busy(busy3), .o_done(done3), .o_stage(stage3), .o_bank(bank3),
        .o_rd_en(rd_en3), .o_rd_addrA(ra3), .o_rd_addrB(rb3), .o_tw_addr(tw3),
        .o_wr_en(we3), .o_wr_addrA(wa3), .o_wr_addrB(wb3));

    fft_stage_sequencer #(.LOG2N(4)) dut4 (
        .i_CLK(clk), .i_RST(rst), .i_start(start4),
`ifdef SEQ_STALL_EN
        .i_stall(stall4),
`endif
        .o_busy(busy4), .o_done(done4), .o_stage(stage4), .o_bank(bank4),
        .o_rd_en(rd_en4), .o_rd_addrA(ra4), .o_rd_addrB(rb4), .o_tw_addr(tw4),
        .o_wr_en(we4), .o_wr_addrA(wa4), .o_wr_addrB(wb4));

    typedef struct {
        int rd_en, a, b, tw, stage, bank, busy, done, we, wa, wb;
    } snap_t;
    typedef struct { int a, b, tw, bank, cyc; } ev_t;
    typedef struct { int a, b, tw, bank; } vec_t;
    typedef struct { int wa, wb; real ar, ai, br, bi; } bf_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    ev_t  obs_rd[$];
    ev_t  obs_wr[$];
    bf_t  pq[$];
    real  ram_re[2][16];
    real  ram_im[2][16];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_real(input string nm, input real act, input real exp);
        real d;
        n_tests++;
        d = act - exp;
        if (d < 0.0) d = -d;
        if (d > 1.0e-6) begin
            n_fail++;
            $display("FAIL %s: got %f, expected %f", nm, act, exp);
        end
    endtask

    // Reference: what the sequencer must present in cycle i after start acceptance.
    function automatic snap_t model(input int l, input int i);
        snap_t e;
        int n, sl, s, j, half;
        e  = '{default: 0};
        n  = 1 << l;
        sl = n / 2 + 2;
        if (i >= 1 && i <= l * sl) begin
            s = (i - 1) / sl;
            j = (i - 1) % sl;
            e.busy  = 1;
            e.stage = s;
            e.bank  = s % 2;
            if (j < n / 2) begin
                half    = 1 << s;
                e.rd_en = 1;
                e.a     = (j / half) * 2 * half + j % half;
                e.b     = e.a + half;
                e.tw    = (j % half) * (n / 2) / half;
            end
        end else if (i == l * sl + 1) begin
            e.done = 1;
            e.bank = l % 2;
        end
        return e;
    endfunction

    function automatic snap_t obs(input int l);
        snap_t o;
        if (l == 3) begin
            o = '{int'(rd_en3), int'(ra3), int'(rb3), int'(tw3), int'(stage3), int'(bank3),
                  int'(busy3), int'(done3), int'(we3), int'(wa3), int'(wb3)};
        end else begin
            o = '{int'(rd_en4), int'(ra4), int'(rb4), int'(tw4), int'(stage4), int'(bank4),
                  int'(busy4), int'(done4), int'(we4), int'(wa4), int'(wb4)};
        end
        return o;
    endfunction

    task automatic set_start(input int l, input logic v);
        if (l == 3) start3 = v; else start4 = v;
    endtask

    task automatic compare(input int l, input int i, input string tag);
        snap_t o, e, w;
        o = obs(l);
        e = model(l, i);
        w = model(l, i - 2);
        chk($sformatf("%s c%0d busy", tag, i), o.busy, e.busy);
        chk($sformatf("%s c%0d done", tag, i), o.done, e.done);
        chk($sformatf("%s c%0d rd_en", tag, i), o.rd_en, e.rd_en);
        chk($sformatf("%s c%0d wr_en", tag, i), o.we, w.rd_en);
        if (e.busy != 0) chk($sformatf("%s c%0d stage", tag, i), o.stage, e.stage);
        if (e.busy != 0 || e.done != 0) chk($sformatf("%s c%0d bank", tag, i), o.bank, e.bank);
        if (e.rd_en != 0) begin
            chk($sformatf("%s c%0d rd_a", tag, i), o.a, e.a);
            chk($sformatf("%s c%0d rd_b", tag, i), o.b, e.b);
            chk($sformatf("%s c%0d tw", tag, i), o.tw, e.tw);
        end
        if (w.rd_en != 0) begin
            chk($sformatf("%s c%0d wr_a", tag, i), o.wa, w.a);
            chk($sformatf("%s c%0d wr_b", tag, i), o.wb, w.b);
        end
    endtask

    // One run from start; rst_at > 0 asserts reset during that cycle instead of finishing.
    task automatic run_seq(input int l, input bit hold, input int rst_at, input string tag);
        int sl, first_done;
        snap_t o;
        sl = (1 << (l - 1)) + 2;
        first_done = -1;
        set_start(l, 1'b1);
        @(posedge clk); #1;
        if (!hold) set_start(l, 1'b0);
        for (int i = 1; i <= l * sl + 2; i++) begin
            o = obs(l);
            if (o.done != 0 && first_done < 0) first_done = i;
            if (o.rd_en != 0) obs_rd.push_back('{o.a, o.b, o.tw, o.bank, i});
            if (o.we != 0) obs_wr.push_back('{o.wa, o.wb, 0, o.bank, i});
            compare(l, i, tag);
            if (i == rst_at) begin
                set_start(l, 1'b0);
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                o = obs(l);
                chk({tag, " rst busy/done/strobes"}, o.busy + o.done + o.rd_en + o.we, 0);
                chk({tag, " rst stage/bank"}, o.stage + o.bank, 0);
                chk({tag, " rst addresses"}, o.a + o.b + o.tw + o.wa + o.wb, 0);
                repeat (4) begin
                    @(posedge clk); #1;
                    o = obs(l);
                    chk({tag, " no write after reset"}, o.we, 0);
                    chk({tag, " no read after reset"}, o.rd_en, 0);
                end
                return;
            end
            if (i == l * sl + 1) set_start(l, 1'b0);
            @(posedge clk); #1;
        end
        chk({tag, " done cycle"}, first_done, l * sl + 1);
    endtask

    function automatic int bitrev4(input int v);
        return ((v & 1) << 3) | ((v & 2) << 1) | ((v & 4) >> 1) | ((v & 8) >> 3);
    endfunction

    // Behavioural RAM/ROM/butterfly driven by the DUT strobes, checked against a direct DFT.
    task automatic run_fft(input bit impulse, input string tag);
        real x[16];
        real wr, wi, tr, ti, er, ei, ang;
        bf_t bf;
        int  done_seen, wbank;
        for (int n = 0; n < 16; n++) begin
            x[n] = impulse ? ((n == 0) ? 1.0 : 0.0) : real'($urandom_range(0, 15));
            ram_re[0][bitrev4(n)] = x[n];
            ram_im[0][bitrev4(n)] = 0.0;
            ram_re[1][n] = 0.0;
            ram_im[1][n] = 0.0;
        end
        pq.delete();
        set_start(4, 1'b1);
        @(posedge clk); #1;
        set_start(4, 1'b0);
        done_seen = 0;
        for (int c = 0; c < 200 && done_seen == 0; c++) begin
            if (we4) begin
                if (pq.size() == 0) begin
                    chk({tag, " write without pending read"}, 1, 0);
                end else begin
                    bf = pq.pop_front();
                    wbank = 1 - int'(bank4);
                    ram_re[wbank][wa4] = bf.ar; ram_im[wbank][wa4] = bf.ai;
                    ram_re[wbank][wb4] = bf.br; ram_im[wbank][wb4] = bf.bi;
                end
            end
            if (rd_en4) begin
                ang = 2.0 * 3.14159265358979 * real'(tw4) / 16.0;
                wr  = $cos(ang);
                wi  = -$sin(ang);
                tr  = ram_re[bank4][rb4] * wr - ram_im[bank4][rb4] * wi;
                ti  = ram_re[bank4][rb4] * wi + ram_im[bank4][rb4] * wr;
                bf  = '{int'(ra4), int'(rb4),
                        ram_re[bank4][ra4] + tr, ram_im[bank4][ra4] + ti,
                        ram_re[bank4][ra4] - tr, ram_im[bank4][ra4] - ti};
                pq.push_back(bf);
            end
            if (done4) done_seen = 1;
            else begin @(posedge clk); #1; end
        end
        chk({tag, " done reached"}, done_seen, 1);
        chk({tag, " result bank"}, int'(bank4), 0);
        for (int m = 0; m < 16; m++) begin
            er = 0.0; ei = 0.0;
            for (int n = 0; n < 16; n++) begin
                ang = 2.0 * 3.14159265358979 * real'((n * m) % 16) / 16.0;
                er += x[n] * $cos(ang);
                ei -= x[n] * $sin(ang);
            end
            chk_real($sformatf("%s bin%0d re", tag, m), ram_re[0][m], er);
            chk_real($sformatf("%s bin%0d im", tag, m), ram_im[0][m], ei);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t tbl[12];
        snap_t o;
        int   rst_at;
        bit   hold;

        tbl = '{'{0,1,0,0}, '{2,3,0,0}, '{4,5,0,0}, '{6,7,0,0},
                '{0,2,0,1}, '{1,3,2,1}, '{4,6,0,1}, '{5,7,2,1},
                '{0,4,0,0}, '{1,5,1,0}, '{2,6,2,0}, '{3,7,3,0}};

        rst = 1'b1; start3 = 1'b0; start4 = 1'b0;
`ifdef SEQ_STALL_EN
        stall3 = 1'b0; stall4 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int l = 3; l <= 4; l++) begin
            o = obs(l);
            chk($sformatf("reset%0d strobes", l), o.busy + o.done + o.rd_en + o.we, 0);
            chk($sformatf("reset%0d stage/bank/addr", l), o.stage + o.bank + o.a + o.b + o.tw + o.wa + o.wb, 0);
        end
        @(posedge clk); #1;

        // Directed LOG2N=3 run with start held high throughout.
        obs_rd.delete(); obs_wr.delete();
        run_seq(3, 1'b1, 0, "n8");
        chk("n8 read count", obs_rd.size(), 12);
        chk("n8 write count", obs_wr.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < obs_rd.size()) begin
                chk($sformatf("tbl%0d rd_a", i), obs_rd[i].a, tbl[i].a);
                chk($sformatf("tbl%0d rd_b", i), obs_rd[i].b, tbl[i].b);
                chk($sformatf("tbl%0d tw", i), obs_rd[i].tw, tbl[i].tw);
                chk($sformatf("tbl%0d bank", i), obs_rd[i].bank, tbl[i].bank);
            end
            if (i < obs_wr.size() && i < obs_rd.size()) begin
                chk($sformatf("tbl%0d wr_a", i), obs_wr[i].a, tbl[i].a);
                chk($sformatf("tbl%0d wr_b", i), obs_wr[i].b, tbl[i].b);
                chk($sformatf("tbl%0d wr delay", i), obs_wr[i].cyc - obs_rd[i].cyc, 2);
            end
        end
        o = obs(3);
        chk("n8 final bank held", o.bank, 1);
        chk("n8 single run", o.busy, 0);

        // Reset during stage 1, k=2.
        @(posedge clk); #1;
        run_seq(3, 1'b0, 9, "n8 rst");

        // Randomized LOG2N=4 runs: idle gaps, held start, occasional mid-run reset.
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
            hold   = 1'($urandom_range(0, 1));
            rst_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 41)) : 0;
            run_seq(4, hold, rst_at, $sformatf("n16 r%0d", r));
        end

        run_fft(1'b1, "impulse");
        run_fft(1'b0, "random fft");

`ifdef SEQ_STALL_EN
        begin
            int first_done;
            int ri;
            first_done = -1;
            ri = 1;
            set_start(4, 1'b1);
            @(posedge clk); #1;
            set_start(4, 1'b0);
            for (int i = 1; i <= 60; i++) begin
                stall4 = (i >= 3 && i <= 5);
                #0;
                if (stall4) chk($sformatf("stall c%0d strobes", i), int'(rd_en4) + int'(we4), 0);
                if (rd_en4) begin
                    while (ri <= 40 && model(4, ri).rd_en == 0) ri++;
                    chk($sformatf("stall seq rd_a %0d", ri), int'(ra4), model(4, ri).a);
                    chk($sformatf("stall seq rd_b %0d", ri), int'(rb4), model(4, ri).b);
                    ri++;
                end
                if (done4 && first_done < 0) first_done = i;
                @(posedge clk); #1;
            end
            stall4 = 1'b0;
            chk("stall done cycle", first_done, 44);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
